uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `uart_transmitter` among `NUM_REQ` byte producers. It accepts one byte at a time from the selected requester and drives the transmitter's `tx_data`/`tx_start`. It tracks completion via `tx_busy`/`tx_done` and reports completion or timeout per transfer. It sits between the client logic (command responder, debug/status streams) and the transmitter.

---
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 116 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte producers, the arbiter and the shared UART transmitter.
// The master modport is the arbiter's view; slave is the client/transmitter side.
interface uart_tx_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*8-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           tx_data;
   logic                 tx_start;
   logic                 tx_busy;
   logic                 tx_done;
   logic [IdW-1:0]       grant_id;
   logic                 active;
   logic                 done_pulse;
   logic                 timeout_err;

   modport master (
      input  req_valid, req_data, tx_busy, tx_done,
      output req_ready, tx_data, tx_start, grant_id, active, done_pulse, timeout_err
   );

   modport slave (
      output req_valid, req_data, tx_busy, tx_done,
      input  req_ready, tx_data, tx_start, grant_id, active, done_pulse, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers,
// with per-transfer completion / timeout reporting. All outputs come straight from flops.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input logic               clk,
   input logic               rst_n,
   uart_tx_arbiter_if.master bus
);
   localparam int unsigned IdW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [0:0] {StIdle, StWaitDone} state_e;

   state_e               state_q, state_d;
   logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IdW-1:0]       grant_q, grant_d;
   logic [7:0]           data_q, data_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   ready_q, ready_d;
   logic                 start_q, start_d;
   logic                 done_q, done_d;
   logic                 tmo_q, tmo_d;
   logic                 win_found;
   logic [IdW-1:0]       win_idx;

   function automatic logic [IdW-1:0] wrap_add(input logic [IdW-1:0] base,
                                               input int unsigned ofs);
      int unsigned sum;
      sum = 32'(base) + ofs;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return IdW'(sum);
   endfunction

   // First pending requester at or above rr_ptr, wrapping back to 0.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!win_found && bus.req_valid[wrap_add(rr_ptr_q, k)]) begin
            win_found = 1'b1;
            win_idx   = wrap_add(rr_ptr_q, k);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      start_d  = 1'b0;
      ready_d  = '0;
      done_d   = 1'b0;
      tmo_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            // A busy transmitter (e.g. after a timeout) is never restarted mid-frame.
            if (win_found && !bus.tx_busy) begin
               state_d          = StWaitDone;
               data_d           = bus.req_data[{win_idx, 3'b000} +: 8];
               start_d          = 1'b1;
               ready_d[win_idx] = 1'b1;
               grant_d          = win_idx;
               rr_ptr_d         = wrap_add(win_idx, 1);
               cnt_d            = '0;
            end
         end
         StWaitDone: begin
            cnt_d = cnt_q + 16'd1;
            if (bus.tx_done) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else if (cnt_q == CntLast) begin
               tmo_d   = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         data_q   <= '0;
         cnt_q    <= '0;
         ready_q  <= '0;
         start_q  <= 1'b0;
         done_q   <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         start_q  <= start_d;
         done_q   <= done_d;
         tmo_q    <= tmo_d;
      end
   end

   assign bus.req_ready   = ready_q;
   assign bus.tx_data     = data_q;
   assign bus.tx_start    = start_q;
   assign bus.grant_id    = grant_q;
   assign bus.active      = (state_q == StWaitDone);
   assign bus.done_pulse  = done_q;
   assign bus.timeout_err = tmo_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the transmitter is modelled by hand-driven busy/done.
module tb_uart_tx_arbiter;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ        (4),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_start"}, 32'(bus.tx_start), 0);
      chk({tag, "_ready"}, 32'(bus.req_ready), 0);
      chk({tag, "_active"}, 32'(bus.active), 0);
      chk({tag, "_done"}, 32'(bus.done_pulse), 0);
      chk({tag, "_tmo"}, 32'(bus.timeout_err), 0);
      chk({tag, "_gid"}, 32'(bus.grant_id), 0);
      chk({tag, "_data"}, 32'(bus.tx_data), 0);
   endtask

   task automatic chk_grant(input string tag, input int unsigned id, input logic [7:0] data);
      chk({tag, "_start"}, 32'(bus.tx_start), 1);
      chk({tag, "_ready"}, 32'(bus.req_ready), 32'(1) << id);
      chk({tag, "_gid"}, 32'(bus.grant_id), id);
      chk({tag, "_data"}, 32'(bus.tx_data), 32'(data));
      chk({tag, "_active"}, 32'(bus.active), 1);
   endtask

   // Transmitter busy for n edges, then done coincident with busy falling.
   task automatic serve(input string tag, input int unsigned n);
      bus.tx_busy = 1'b1;
      tick();
      chk({tag, "_start_once"}, 32'(bus.tx_start), 0);
      chk({tag, "_ready_once"}, 32'(bus.req_ready), 0);
      repeat (n - 1) tick();
      bus.tx_done = 1'b1;
      bus.tx_busy = 1'b0;
      tick();
      chk({tag, "_done"}, 32'(bus.done_pulse), 1);
      chk({tag, "_done_no_tmo"}, 32'(bus.timeout_err), 0);
      chk({tag, "_inactive"}, 32'(bus.active), 0);
      bus.tx_done = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      chk_all_zero("reset");
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b1;
      bus.req_valid = '0;
      bus.req_data  = 32'h13121110;
      bus.tx_busy   = 1'b0;
      bus.tx_done   = 1'b0;
      #2;
      pulse_reset();

      // Single requester 2 with byte A5.
      bus.req_data  = 32'h13A51110;
      bus.req_valid = 4'b0100;
      tick();
      chk_grant("single", 2, 8'hA5);
      bus.req_valid = 4'b0000;
      serve("single", 4);
      tick();
      chk("single_done_once", 32'(bus.done_pulse), 0);
      chk("single_no_regrant", 32'(bus.tx_start), 0);
      chk("single_gid_kept", 32'(bus.grant_id), 2);

      // tx_done while idle is ignored.
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      chk("idle_done_ignored", 32'(bus.done_pulse), 0);
      chk("idle_done_inactive", 32'(bus.active), 0);

      // Round-robin with all four requesters held valid.
      pulse_reset();
      bus.req_data  = 32'h13121110;
      bus.req_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_grant("rr", i % 4, 8'h10 + 8'(i % 4));
         serve("rr", 3);
      end
      bus.req_valid = 4'b0000;
      tick();

      // Fairness after wrap: put rr_ptr at 3, then 4'b1001 grants 3 then 0.
      pulse_reset();
      bus.req_valid = 4'b0100;
      tick();
      chk_grant("ptr3", 2, 8'h12);
      bus.req_valid = 4'b0000;
      serve("ptr3", 2);
      bus.req_valid = 4'b1001;
      bus.tx_busy   = 1'b1;
      tick();
      chk("idle_busy_no_grant", 32'(bus.tx_start), 0);
      chk("idle_busy_inactive", 32'(bus.active), 0);
      bus.tx_busy = 1'b0;
      tick();
      chk_grant("wrap_a", 3, 8'h13);
      bus.req_valid = 4'b0001;
      serve("wrap_a", 2);
      tick();
      chk_grant("wrap_b", 0, 8'h10);
      bus.req_valid = 4'b0000;
      serve("wrap_b", 2);

      // Timeout: transmitter stays busy and never signals done.
      bus.req_valid = 4'b0001;
      tick();
      chk_grant("tmo", 0, 8'h10);
      bus.tx_busy = 1'b1;
      for (int i = 1; i < 20; i++) begin
         tick();
         chk("tmo_not_yet", 32'(bus.timeout_err), 0);
         chk("tmo_active", 32'(bus.active), 1);
      end
      tick();
      chk("tmo_pulse", 32'(bus.timeout_err), 1);
      chk("tmo_no_done", 32'(bus.done_pulse), 0);
      chk("tmo_inactive", 32'(bus.active), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("tmo_hold_no_start", 32'(bus.tx_start), 0);
         chk("tmo_single_pulse", 32'(bus.timeout_err), 0);
      end
      bus.tx_busy = 1'b0;
      tick();
      chk_grant("tmo_recover", 0, 8'h10);
      bus.req_valid = 4'b0000;
      serve("tmo_recover", 2);

      // Done on the expiry cycle wins over timeout.
      bus.req_valid = 4'b0010;
      tick();
      chk_grant("tie", 1, 8'h11);
      bus.req_valid = 4'b0000;
      bus.tx_busy   = 1'b1;
      repeat (19) tick();
      chk("tie_pre_active", 32'(bus.active), 1);
      bus.tx_done = 1'b1;
      bus.tx_busy = 1'b0;
      tick();
      bus.tx_done = 1'b0;
      chk("tie_done", 32'(bus.done_pulse), 1);
      chk("tie_no_tmo", 32'(bus.timeout_err), 0);
      tick();
      chk("tie_no_late_tmo", 32'(bus.timeout_err), 0);

      // Reset mid-frame, then a pending request scans from 0.
      bus.req_valid = 4'b1000;
      tick();
      chk_grant("mid", 3, 8'h13);
      bus.req_valid = 4'b0000;
      bus.tx_busy   = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      bus.tx_busy   = 1'b0;
      bus.req_valid = 4'b1100;
      tick();
      rst_n = 1'b1;
      tick();
      chk_grant("post_reset", 2, 8'h12);
      chk("post_reset_no_done", 32'(bus.done_pulse), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
